// File: rtl/bi_quin_pkg.sv
// Shared types, constants and coding helpers for the biquinary decade counter.
package bi_quin_pkg;

  localparam int unsigned QUIN_MAX = 4;
  localparam int unsigned DEC_MAX  = 9;

  typedef struct packed {
    logic       bi;
    logic [2:0] quin;
  } digit_t;

  typedef enum logic {
    CODE_BCD    = 1'b0,
    CODE_BIQUIN = 1'b1
  } code_t;

  // Nibbles above 9 map to the zero digit; callers flag the error separately.
  function automatic digit_t bcd_to_biquin(input logic [3:0] d);
    digit_t r;
    r = '0;
    if (d > 4'(DEC_MAX)) begin
      r = '0;
    end else if (d >= 4'd5) begin
      r.bi   = 1'b1;
      r.quin = 3'(d - 4'd5);
    end else begin
      r.quin = d[2:0];
    end
    return r;
  endfunction

  function automatic logic [3:0] biquin_to_bcd(input digit_t s);
    return {1'b0, s.quin} + (s.bi ? 4'd5 : 4'd0);
  endfunction

endpackage

// File: rtl/bi_quin_digit.sv
// One biquinary decade: mod-2 bi stage (weight 5) and mod-5 quin stage (4-2-1).
module bi_quin_digit
  import bi_quin_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_nibble,
  output logic [3:0] state,
  output logic       at_max,
  output logic       at_min,
  output logic       nib_err
);

  digit_t s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= '0;
    end else if (load) begin
      s <= bcd_to_biquin(load_nibble);
    end else if (step) begin
      if (s.quin > 3'(QUIN_MAX)) begin
        s.quin <= '0;
      end else if (up) begin
        if (s.quin == 3'(QUIN_MAX)) begin
          s.quin <= '0;
          s.bi   <= ~s.bi;
        end else begin
          s.quin <= s.quin + 3'd1;
        end
      end else begin
        if (s.quin == '0) begin
          s.quin <= 3'(QUIN_MAX);
          s.bi   <= ~s.bi;
        end else begin
          s.quin <= s.quin - 3'd1;
        end
      end
    end
  end

  assign state   = s;
  assign at_max  = s.bi & (s.quin == 3'(QUIN_MAX));
  assign at_min  = ~s.bi & (s.quin == '0);
  assign nib_err = load_nibble > 4'(DEC_MAX);

endmodule

// File: rtl/bi_quin_cascade.sv
// Multi-decade up/down biquinary counter with load, selectable output coding,
// terminal-count, wrap and load-error flags.
module bi_quin_cascade
  import bi_quin_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                code_sel,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] nib_err;
  logic [3:0]        st [DIGITS];

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic carry_in;
      // Each digit looks at all lower digits directly, so every decade steps on the same edge.
      if (i == 0) begin : g_lsd
        assign carry_in = 1'b1;
      end else begin : g_upper
        assign carry_in = up ? &at_max[i-1:0] : &at_min[i-1:0];
      end

      assign step[i] = en & ~load & carry_in;

      bi_quin_digit u_digit (
        .clk         (clk),
        .rst         (rst),
        .step        (step[i]),
        .up          (up),
        .load        (load),
        .load_nibble (load_val[4*i +: 4]),
        .state       (st[i]),
        .at_max      (at_max[i]),
        .at_min      (at_min[i]),
        .nib_err     (nib_err[i])
      );

      assign q[4*i +: 4] = (code_t'(code_sel) == CODE_BIQUIN) ? st[i]
                                                              : biquin_to_bcd(digit_t'(st[i]));
    end
  endgenerate

  assign tc = en & ~load & (up ? &at_max : &at_min);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap <= tc;
      if (load) begin
        load_err <= |nib_err;
      end
    end
  end

endmodule

// File: tb/tb_bi_quin_cascade.sv
// Self-checking bench for bi_quin_cascade (DIGITS=2): decimal-value reference model plus directed literals.
module tb_bi_quin_cascade;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       code_sel = 1'b0;
  logic [7:0] q;
  logic       tc;
  logic       wrap;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  bit m_wrap = 0;
  bit m_err = 0;
  bit m_valid = 0;

  bi_quin_cascade #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .code_sel (code_sel),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output for a decimal count 0..99 in either coding.
  function automatic logic [7:0] enc(input int v, input bit biq);
    int d [2];
    logic [7:0] r;
    d[0] = v % 10;
    d[1] = v / 10;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      int c;
      c = (biq && d[i] >= 5) ? d[i] + 3 : d[i];
      r[4*i +: 4] = 4'(c);
    end
    return r;
  endfunction

  // Reference model: the count as an integer 0..99.
  always @(posedge clk) begin
    if (!rst) begin
      m_cnt = 0;
      m_wrap = 0;
      m_err = 0;
      m_valid = 1;
    end else if (load) begin
      int hi, lo;
      hi = int'(load_val[7:4]);
      lo = int'(load_val[3:0]);
      m_err = (hi > 9) || (lo > 9);
      if (hi > 9) hi = 0;
      if (lo > 9) lo = 0;
      m_cnt = hi * 10 + lo;
      m_wrap = 0;
    end else if (en) begin
      m_wrap = up ? (m_cnt == 99) : (m_cnt == 0);
      m_cnt = up ? (m_cnt + 1) % 100 : (m_cnt + 99) % 100;
    end else begin
      m_wrap = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("q", 32'(q), 32'(enc(m_cnt, code_sel)));
      chk("tc", 32'(tc), 32'(en & ~load & (up ? (m_cnt == 99) : (m_cnt == 0))));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("load_err", 32'(load_err), 32'(m_err));
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_val = v;
    clk1();
    load = 1'b0;
  endtask

  initial begin
    // Reset then hold
    rst = 1'b0;
    repeat (2) clk1();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_err", 32'(load_err), 0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clk1();
      chk("hold_q", 32'(q), 32'h00);
      chk("hold_wrap", 32'(wrap), 0);
    end

    // Up count in BCD
    en = 1'b1;
    up = 1'b1;
    code_sel = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      clk1();
      chk("upcnt_q", 32'(q), 32'((k / 10) * 16 + (k % 10)));
    end
    en = 1'b0;

    // Biquinary view of 57, then switching coding without a clock
    do_load(8'h57);
    code_sel = 1'b1;
    #1;
    chk("biq_57", 32'(q), 32'h8A);
    code_sel = 1'b0;
    #1;
    chk("bcd_57", 32'(q), 32'h57);

    // Up wrap
    do_load(8'h98);
    en = 1'b1;
    up = 1'b1;
    clk1();
    chk("upw_99", 32'(q), 32'h99);
    chk("upw_tc", 32'(tc), 1);
    clk1();
    chk("upw_00", 32'(q), 32'h00);
    chk("upw_wrap", 32'(wrap), 1);
    clk1();
    chk("upw_01", 32'(q), 32'h01);
    chk("upw_wrap_off", 32'(wrap), 0);
    en = 1'b0;

    // Down wrap
    do_load(8'h01);
    chk("dnw_ld_wrap", 32'(wrap), 0);
    up = 1'b0;
    en = 1'b1;
    clk1();
    chk("dnw_00", 32'(q), 32'h00);
    chk("dnw_tc", 32'(tc), 1);
    clk1();
    chk("dnw_99", 32'(q), 32'h99);
    chk("dnw_wrap", 32'(wrap), 1);
    clk1();
    chk("dnw_98", 32'(q), 32'h98);
    chk("dnw_wrap_off", 32'(wrap), 0);

    // Load precedence and error flag
    load = 1'b1;
    load_val = 8'h3C;
    #1;
    chk("ld_tc_masked", 32'(tc), 0);
    clk1();
    chk("ld_3c_q", 32'(q), 32'h30);
    chk("ld_3c_err", 32'(load_err), 1);
    load_val = 8'h25;
    clk1();
    chk("ld_25_q", 32'(q), 32'h25);
    chk("ld_25_err", 32'(load_err), 0);
    load_val = 8'h46;
    clk1();
    load = 1'b0;
    up = 1'b1;
    clk1();
    chk("mid_47", 32'(q), 32'h47);
    rst = 1'b0;
    clk1();
    chk("mid_rst_q", 32'(q), 32'h00);
    rst = 1'b1;

    // Randomised phase, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(99) >= 2);
      load     = ($urandom_range(99) < 8);
      load_val = 8'($urandom);
      en       = ($urandom_range(99) < 75);
      up       = (k % 400 < 200) ? ($urandom_range(9) != 0) : ($urandom_range(9) == 0);
      code_sel = 1'($urandom);
      clk1();
    end
    en = 1'b0;
    load = 1'b0;
    rst = 1'b1;
    repeat (2) clk1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
